mem_bus_arbiter: RTL and testbench

//  N-master arbiter and serialiser for the byte-wide system memory bus (RAM + HCI IO window).

---
 rtl/mem_bus_arb_pkg.sv | 13 +
 rtl/mem_bus_arbiter_rr.sv | 51 +++++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the byte-wide memory bus arbiter/serialiser.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

    localparam logic [1:0] IO_WINDOW = 2'b11;
    localparam int         LEN_W     = 2;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [LEN_W-1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Request arbiter: round-robin from i_ptr+1 with wrap, or fixed lowest-index-wins
// priority when MEM_BUS_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;

`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end
`else
    // Two passes give the wrapped search order: indices above the pointer first, then the rest.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j > int'(i_ptr))) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j <= int'(i_ptr))) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master arbiter and byte serialiser for the system memory bus (RAM + HCI IO window).
// Define MEM_BUS_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [NUM_MASTERS-1:0]            req_in,
    input  logic [NUM_MASTERS-1:0]            wr_in,
    input  logic [LEN_W*NUM_MASTERS-1:0]      len_in,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] addr_in,
    input  logic [32*NUM_MASTERS-1:0]         wdata_in,
    output logic [NUM_MASTERS-1:0]            gnt_out,
    output logic [NUM_MASTERS-1:0]            done_out,
    output logic [31:0]                       rdata_out,
    output logic                              busy_out,
    output logic [ADDR_WIDTH-1:0]             mem_a_out,
    output logic                              mem_wr_out,
    output logic [7:0]                        mem_dout,
    input  logic [7:0]                        mem_din,
    output logic                              io_en_out
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    state_t                r_state;
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      r_len;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_ptr;
    logic [31:0]           r_rdata;
    logic                  r_iss;
    logic [LEN_W-1:0]      r_iss_idx;

    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [LEN_W-1:0]       w_sel_len;
    logic                   w_sel_wr;
    logic [31:0]            w_sel_wdata;

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req (req_in),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_wr    = 1'b0;
        w_sel_wdata = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (IDX_W'(j) == w_gnt_idx) begin
                w_sel_addr  = addr_in[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len   = len_in[j*LEN_W +: LEN_W];
                w_sel_wr    = wr_in[j];
                w_sel_wdata = wdata_in[j*32 +: 32];
            end
        end
    end

    // Read data returns one cycle after its address; r_iss marks that a read byte was issued last cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_wr      <= 1'b0;
            r_base    <= '0;
            r_wdata   <= '0;
            r_idx     <= '0;
            r_ptr     <= IDX_W'(NUM_MASTERS - 1);
            r_rdata   <= '0;
            r_iss     <= 1'b0;
            r_iss_idx <= '0;
        end else begin
            r_iss <= 1'b0;
            if (r_iss) begin
                r_rdata[{r_iss_idx, 3'b000} +: 8] <= mem_din;
            end
            if (rdy_in) begin
                case (r_state)
                    IDLE: begin
                        if (|req_in) begin
                            r_base  <= w_sel_addr;
                            r_len   <= w_sel_len;
                            r_wr    <= w_sel_wr;
                            r_wdata <= w_sel_wdata;
                            r_idx   <= w_gnt_idx;
                            r_ptr   <= w_gnt_idx;
                            r_rdata <= '0;
                            r_cnt   <= '0;
                            r_state <= XFER;
                        end
                    end
                    XFER: begin
                        r_iss     <= ~r_wr;
                        r_iss_idx <= r_cnt;
                        if (r_cnt == r_len) begin
                            r_state <= r_wr ? DONE : TAIL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    TAIL:    r_state <= DONE;
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Bus and handshake outputs decode the registered state; a pause suppresses strobes and pulses.
    always_comb begin
        gnt_out    = '0;
        done_out   = '0;
        mem_a_out  = '0;
        mem_wr_out = 1'b0;
        mem_dout   = '0;
        if (!rst_in) begin
            case (r_state)
                IDLE: begin
                    if (rdy_in) gnt_out = w_gnt;
                end
                XFER: begin
                    mem_a_out  = r_base + ADDR_WIDTH'(r_cnt);
                    mem_wr_out = r_wr & rdy_in;
                    mem_dout   = byte_of(r_wdata, r_cnt);
                end
                DONE: begin
                    for (int j = 0; j < NUM_MASTERS; j++) begin
                        if (rdy_in && (IDX_W'(j) == r_idx)) done_out[j] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_en_out = (mem_a_out[RAM_ADDR_WIDTH -: 2] == IO_WINDOW);
    assign rdata_out = r_rdata;
    assign busy_out  = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter with a small registered-read RAM model.
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [1:0]  req_in;
    logic [1:0]  wr_in;
    logic [3:0]  len_in;
    logic [63:0] addr_in;
    logic [63:0] wdata_in;
    logic [1:0]  gnt_out;
    logic [1:0]  done_out;
    logic [31:0] rdata_out;
    logic        busy_out;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_en_out;

    logic [7:0] ram [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter #(
        .NUM_MASTERS    (2),
        .ADDR_WIDTH     (32),
        .RAM_ADDR_WIDTH (17)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .req_in     (req_in),
        .wr_in      (wr_in),
        .len_in     (len_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .gnt_out    (gnt_out),
        .done_out   (done_out),
        .rdata_out  (rdata_out),
        .busy_out   (busy_out),
        .mem_a_out  (mem_a_out),
        .mem_wr_out (mem_wr_out),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .io_en_out  (io_en_out)
    );

    always @(posedge clk_in) mem_din <= ram[mem_a_out[9:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        int         ng;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11;
        ram[10'h101] = 8'h22;
        ram[10'h102] = 8'h33;
        ram[10'h103] = 8'h44;

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        req_in   = 2'b00;
        wr_in    = 2'b00;
        len_in   = 4'h0;
        addr_in  = '0;
        wdata_in = '0;
        repeat (3) tick();
        req_in = 2'b11;
        #4;
        chk("rst_busy", busy_out, 0);
        chk("rst_gnt", gnt_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_mem_a", mem_a_out, 0);
        chk("rst_rdata", rdata_out, 0);
        tick();
        rst_in = 1'b0;
        req_in = 2'b00;

        // Test 1: M0 read of four bytes at 0x100
        tick();
        req_in  = 2'b01;
        wr_in   = 2'b00;
        len_in  = 4'b0011;
        addr_in = {32'h0, 32'h0000_0100};
        #4;
        chk("t1_gnt", gnt_out, 2'b01);
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_in = 2'b00;
            #4;
            chk("t1_mem_a", mem_a_out, (c <= 4) ? (32'h100 + c - 1) : 32'h0);
            chk("t1_wr", mem_wr_out, 0);
            chk("t1_done", done_out, (c == 6) ? 2'b01 : 2'b00);
        end
        chk("t1_rdata", rdata_out, 32'h4433_2211);

        // Test 2: M1 two-byte write into the IO window
        tick();
        req_in   = 2'b10;
        wr_in    = 2'b10;
        len_in   = 4'b0100;
        addr_in  = {32'h0003_0000, 32'h0};
        wdata_in = {32'h0000_BEEF, 32'h0};
        #4;
        chk("t2_gnt", gnt_out, 2'b10);
        for (int c = 1; c <= 3; c++) begin
            tick();
            req_in = 2'b00;
            wr_in  = 2'b00;
            #4;
            chk("t2_mem_a", mem_a_out, (c <= 2) ? (32'h3_0000 + c - 1) : 32'h0);
            chk("t2_io_en", io_en_out, (c <= 2) ? 1 : 0);
            chk("t2_wr", mem_wr_out, (c <= 2) ? 1 : 0);
            chk("t2_dout", mem_dout, (c == 1) ? 8'hEF : (c == 2) ? 8'hBE : 8'h00);
            chk("t2_done", done_out, (c == 3) ? 2'b10 : 2'b00);
        end

        // Test 3: both masters requesting single-byte writes continuously
        tick();
        req_in   = 2'b11;
        wr_in    = 2'b11;
        len_in   = 4'b0000;
        addr_in  = {32'h0000_0204, 32'h0000_0200};
        wdata_in = {32'h0000_0055, 32'h0000_00AA};
        exp_g    = 2'b01;
        ng       = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            #4;
            if (gnt_out != 2'b00) begin
                chk("t3_gnt", gnt_out, exp_g);
                ng++;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
                exp_g = {exp_g[0], exp_g[1]};
`endif
            end
        end
        chk("t3_grants", ng, 4);
        tick();
        req_in = 2'b00;
        wr_in  = 2'b00;
        #4;
        chk("t3_idle", busy_out, 0);

        // Test 4: four-byte read with a three-cycle pause in the middle
        tick();
        req_in  = 2'b01;
        wr_in   = 2'b00;
        len_in  = 4'b0011;
        addr_in = {32'h0, 32'h0000_0100};
        #4;
        chk("t4_gnt", gnt_out, 2'b01);
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_in = 2'b00;
            rdy_in = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #4;
            chk("t4_mem_a", mem_a_out,
                (c == 1) ? 32'h100 : (c == 2) ? 32'h101 : (c <= 6) ? 32'h102 : (c == 7) ? 32'h103 : 32'h0);
            chk("t4_wr", mem_wr_out, 0);
            chk("t4_done", done_out, (c == 9) ? 2'b01 : 2'b00);
        end
        chk("t4_rdata", rdata_out, 32'h4433_2211);

        // Test 5a: four-byte write wrapping past the top of the address space
        tick();
        req_in   = 2'b10;
        wr_in    = 2'b10;
        len_in   = 4'b1100;
        addr_in  = {32'hFFFF_FFFE, 32'h0};
        wdata_in = {32'hDDCC_BBAA, 32'h0};
        #4;
        chk("t5_gnt", gnt_out, 2'b10);
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_in = 2'b00;
            #4;
            chk("t5_mem_a", mem_a_out,
                (c == 1) ? 32'hFFFF_FFFE : (c == 2) ? 32'hFFFF_FFFF : (c == 4) ? 32'h1 : 32'h0);
            chk("t5_io_en", io_en_out, (c <= 2) ? 1 : 0);
            chk("t5_wr", mem_wr_out, (c <= 4) ? 1 : 0);
            chk("t5_dout", mem_dout, (c <= 4) ? (8'hAA + 8'h11 * (c - 1)) : 0);
            chk("t5_done", done_out, (c == 5) ? 2'b10 : 2'b00);
        end

        // Test 5b: same write, reset asserted on the second byte
        tick();
        req_in = 2'b10;
        #4;
        chk("t5b_gnt", gnt_out, 2'b10);
        tick();
        req_in = 2'b00;
        #4;
        chk("t5b_a0", mem_a_out, 32'hFFFF_FFFE);
        tick();
        #4;
        chk("t5b_a1", mem_a_out, 32'hFFFF_FFFF);
        rst_in = 1'b1;
        tick();
        req_in = 2'b10;
        #4;
        chk("t5b_busy", busy_out, 0);
        chk("t5b_mem_a", mem_a_out, 0);
        chk("t5b_wr", mem_wr_out, 0);
        chk("t5b_dout", mem_dout, 0);
        chk("t5b_gnt_rst", gnt_out, 0);
        chk("t5b_done", done_out, 0);
        chk("t5b_rdata", rdata_out, 0);
        tick();
        rst_in = 1'b0;
        req_in = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk("t5b_no_done", done_out, 0);
            chk("t5b_idle", busy_out, 0);
            tick();
        end

        // Test 6: request withdrawn while the bus is paused is never granted
        rdy_in = 1'b0;
        req_in = 2'b01;
        #4;
        chk("t6_gnt_paused", gnt_out, 0);
        tick();
        rdy_in = 1'b1;
        req_in = 2'b00;
        #4;
        chk("t6_gnt_dropped", gnt_out, 0);
        tick();
        #4;
        chk("t6_idle", busy_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
